// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : cpu_pipe_pkg                                                   |
// | Purpose : Shared definitions for the pipeline stage registers: default   |
// |           widths, stall-vector stage indices, the write-back channel     |
// |           record and a writer-qualification helper.                      |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial multi-issue release                               |
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pipe_pkg;

  localparam int REG_AW_DEF  = 5;
  localparam int DW_DEF      = 32;
  localparam int STALL_W_DEF = 6;

  // Bit positions in the stall vector, oldest stage first.
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  // One write-back channel at the default widths.
  typedef struct packed {
    logic                  valid;
    logic                  wreg;
    logic [REG_AW_DEF-1:0] wd;
    logic [DW_DEF-1:0]     wdata;
  } wb_ch_t;

  // A channel only writes the regfile when it carries a live instruction.
  function automatic logic is_writer(input logic valid, input logic wreg);
    return valid & wreg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_pipe_if.sv
// ---------------------------------------------------------------------------
// | Module  : mem_wb_pipe_if                                                 |
// | Purpose : Bundle of MEM-side inputs and WB-side outputs of the MEM->WB   |
// |           stage register.                                                |
// | Ports   : mem_* (from mem stage), wb_* (to regfile/hilo/LLbit)           |
// |           modport slave  : the pipeline register (reads mem_*, drives wb_*)|
// |           modport master : the environment (drives mem_*, reads wb_*)    |
// | Rev     : 1.0  initial multi-issue release                               |
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_wb_pipe_if
  import cpu_pipe_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DW     = DW_DEF
);

  logic [NUM_CH-1:0]        mem_valid;
  logic [NUM_CH*REG_AW-1:0] mem_wd;
  logic [NUM_CH*DW-1:0]     mem_wdata;
  logic [NUM_CH-1:0]        mem_wreg;
  logic                     mem_whilo;
  logic [DW-1:0]            mem_hi;
  logic [DW-1:0]            mem_lo;
  logic                     mem_LLbit_we;
  logic                     mem_LLbit_value;

  logic [NUM_CH-1:0]        wb_valid;
  logic [NUM_CH*REG_AW-1:0] wb_wd;
  logic [NUM_CH*DW-1:0]     wb_wdata;
  logic [NUM_CH-1:0]        wb_wreg;
  logic                     wb_whilo;
  logic [DW-1:0]            wb_hi;
  logic [DW-1:0]            wb_lo;
  logic                     wb_LLbit_we;
  logic                     wb_LLbit_value;

  modport slave (
    input  mem_valid, mem_wd, mem_wdata, mem_wreg, mem_whilo, mem_hi, mem_lo,
           mem_LLbit_we, mem_LLbit_value,
    output wb_valid, wb_wd, wb_wdata, wb_wreg, wb_whilo, wb_hi, wb_lo,
           wb_LLbit_we, wb_LLbit_value
  );

  modport master (
    output mem_valid, mem_wd, mem_wdata, mem_wreg, mem_whilo, mem_hi, mem_lo,
           mem_LLbit_we, mem_LLbit_value,
    input  wb_valid, wb_wd, wb_wdata, wb_wreg, wb_whilo, wb_hi, wb_lo,
           wb_LLbit_we, wb_LLbit_value
  );

endinterface

`default_nettype wire

// File: rtl/wb_dup_squash.sv
// ---------------------------------------------------------------------------
// | Module  : wb_dup_squash                                                  |
// | Purpose : Combinational intra-bundle duplicate-destination squash. When  |
// |           two writing channels target the same register, only the        |
// |           highest-index (youngest) keeps its write enable.               |
// | Ports   : i_valid [NUM_CH]        channel valid                          |
// |           i_wreg  [NUM_CH]        channel regfile write enable           |
// |           i_wd    [NUM_CH*REG_AW] channel destination                    |
// |           o_wreg  [NUM_CH]        qualified, de-duplicated write enable  |
// | Rev     : 1.0  initial multi-issue release                               |
// ---------------------------------------------------------------------------
`default_nettype none

module wb_dup_squash
  import cpu_pipe_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [NUM_CH-1:0]        i_valid,
  input  logic [NUM_CH-1:0]        i_wreg,
  input  logic [NUM_CH*REG_AW-1:0] i_wd,
  output logic [NUM_CH-1:0]        o_wreg
);

  // With NUM_CH=1 the inner loop is empty and this is a plain valid&wreg.
  always_comb begin
    o_wreg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      o_wreg[i] = is_writer(i_valid[i], i_wreg[i]);
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (is_writer(i_valid[j], i_wreg[j]) &&
            (i_wd[j*REG_AW +: REG_AW] == i_wd[i*REG_AW +: REG_AW])) begin
          o_wreg[i] = 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// | Module  : mem_wb_pipe                                                    |
// | Purpose : NUM_CH-wide MEM->WB pipeline register with per-channel valid,  |
// |           flush-over-stall priority, duplicate-destination squash and    |
// |           stall/bubble control from stall[STAGE]/stall[STAGE+1].         |
// | Ports   : clk, rst (async, active-low), stall[STALL_W], flush,           |
// |           bus (mem_wb_pipe_if.slave),                                    |
// |           perf_bubble_cnt/perf_hold_cnt (only with MEM_WB_PIPE_PERF_EN)  |
// | Config  : `define MEM_WB_PIPE_PERF_EN adds bubble/hold event counters.   |
// | Rev     : 1.0  initial multi-issue release                               |
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wb_pipe
  import cpu_pipe_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int STALL_W = STALL_W_DEF,
  parameter int STAGE   = STG_MEM   // STAGE+1 must index a valid stall bit
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  mem_wb_pipe_if.slave       bus
`ifdef MEM_WB_PIPE_PERF_EN
  ,
  output logic [31:0]        perf_bubble_cnt,
  output logic [31:0]        perf_hold_cnt
`endif
);

  localparam logic [1:0] ACT_ADV  = 2'd0;
  localparam logic [1:0] ACT_BUB  = 2'd1;
  localparam logic [1:0] ACT_HOLD = 2'd2;

  logic [1:0]               w_act;
  logic                     w_any_valid;
  logic [NUM_CH-1:0]        w_wreg;
  logic [NUM_CH*REG_AW-1:0] w_wd;
  logic [NUM_CH*DW-1:0]     w_wdata;

  logic [NUM_CH-1:0]        r_valid;
  logic [NUM_CH-1:0]        r_wreg;
  logic [NUM_CH*REG_AW-1:0] r_wd;
  logic [NUM_CH*DW-1:0]     r_wdata;
  logic                     r_whilo;
  logic [DW-1:0]            r_hi;
  logic [DW-1:0]            r_lo;
  logic                     r_llwe;
  logic                     r_llv;

  // Flush beats any stall; otherwise the downstream stall bit decides
  // between inserting a bubble and holding the current contents.
  always_comb begin
    w_act = ACT_ADV;
    if (flush)                    w_act = ACT_BUB;
    else if (!stall[STAGE])       w_act = ACT_ADV;
    else if (!stall[STAGE+1])     w_act = ACT_BUB;
    else                          w_act = ACT_HOLD;
  end

  assign w_any_valid = |bus.mem_valid;

  // Invalid channels present all-zero address/data so WB never sees stale
  // mem-stage values on a dead lane.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_wd[gi*REG_AW +: REG_AW] = bus.mem_valid[gi] ? bus.mem_wd[gi*REG_AW +: REG_AW] : '0;
    assign w_wdata[gi*DW +: DW]      = bus.mem_valid[gi] ? bus.mem_wdata[gi*DW +: DW]      : '0;
  end

  wb_dup_squash #(
    .NUM_CH (NUM_CH),
    .REG_AW (REG_AW)
  ) u_squash (
    .i_valid (bus.mem_valid),
    .i_wreg  (bus.mem_wreg),
    .i_wd    (bus.mem_wd),
    .o_wreg  (w_wreg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_wreg  <= '0;
      r_wd    <= '0;
      r_wdata <= '0;
      r_whilo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_llwe  <= 1'b0;
      r_llv   <= 1'b0;
    end else begin
      case (w_act)
        ACT_ADV: begin
          r_valid <= bus.mem_valid;
          r_wreg  <= w_wreg;
          r_wd    <= w_wd;
          r_wdata <= w_wdata;
          r_whilo <= bus.mem_whilo & w_any_valid;
          r_hi    <= bus.mem_hi;
          r_lo    <= bus.mem_lo;
          r_llwe  <= bus.mem_LLbit_we & w_any_valid;
          r_llv   <= bus.mem_LLbit_value;
        end
        ACT_BUB: begin
          r_valid <= '0;
          r_wreg  <= '0;
          r_wd    <= '0;
          r_wdata <= '0;
          r_whilo <= 1'b0;
          r_hi    <= '0;
          r_lo    <= '0;
          r_llwe  <= 1'b0;
          r_llv   <= 1'b0;
        end
        default: ;  // hold
      endcase
    end
  end

  assign bus.wb_valid       = r_valid;
  assign bus.wb_wreg        = r_wreg;
  assign bus.wb_wd          = r_wd;
  assign bus.wb_wdata       = r_wdata;
  assign bus.wb_whilo       = r_whilo;
  assign bus.wb_hi          = r_hi;
  assign bus.wb_lo          = r_lo;
  assign bus.wb_LLbit_we    = r_llwe;
  assign bus.wb_LLbit_value = r_llv;

`ifdef MEM_WB_PIPE_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_hold_cnt;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
      r_hold_cnt   <= '0;
    end else begin
      if (w_act == ACT_BUB)  r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_act == ACT_HOLD) r_hold_cnt   <= r_hold_cnt + 32'd1;
    end
  end

  assign perf_bubble_cnt = r_bubble_cnt;
  assign perf_hold_cnt   = r_hold_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM->WB pipeline register for the multi-issue core. Carries NUM_CH write-back channels, plus one shared HI/LO write and one LLbit write per bundle, from the memory stage to the write-back stage. Adds the following to the single-issue stage register:
- per-channel valid bits
- flush with priority over stall
- intra-bundle duplicate-destination squash
- stall/bubble semantics indexed by a STAGE parameter

Sits between the mem stage and the regfile/hilo/LLbit write ports; driven by the central stall controller.

Parameters:
NUM_CH, 2, number of parallel write-back channels (1..4)
REG_AW, 5, register-file address width
DW, 32, data width of wdata/hi/lo
STALL_W, 6, width of the stall vector
STAGE, 4, index of this register's stall bit; STAGE+1 must be < STALL_W

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
stall  in  STALL_W  stall vector from the stall controller
flush  in  1  exception/ERET flush; squashes the bundle being captured
mem_valid  in  NUM_CH  per-channel instruction valid
mem_wd  in  NUM_CH*REG_AW  per-channel destination register; channel i at [i*REG_AW +: REG_AW]
mem_wdata  in  NUM_CH*DW  per-channel write data
mem_wreg  in  NUM_CH  per-channel regfile write enable
mem_whilo  in  1  HI/LO write enable for the bundle
mem_hi, mem_lo  in  DW each  HI/LO values
mem_LLbit_we, mem_LLbit_value  in  1 each  LLbit update
wb_valid  out  NUM_CH  registered valid
wb_wd  out  NUM_CH*REG_AW  registered destinations
wb_wdata  out  NUM_CH*DW  registered data
wb_wreg  out  NUM_CH  registered write enables, after squash
wb_whilo, wb_hi, wb_lo, wb_LLbit_we, wb_LLbit_value  out  1/DW/DW/1/1  registered shared fields

Behaviour:
- Reset: rst=0 asynchronously clears every output to 0, including valid and enables. Release is synchronous to clk; the first capture is on the first edge with rst=1.
- Latency: 1 cycle, input to output.
- Action per rising edge, in priority order:
  1. flush=1 -> load bubble: all outputs 0. This holds regardless of stall.
  2. stall[STAGE]=0 -> advance: capture all inputs, with the qualification rules below.
  3. stall[STAGE]=1 and stall[STAGE+1]=0 -> insert bubble: all outputs 0.
  4. stall[STAGE]=1 and stall[STAGE+1]=1 -> hold: all outputs keep their values.
- Qualification on advance:
  - wb_wreg[i] = mem_wreg[i] & mem_valid[i].
  - wb_whilo and wb_LLbit_we are gated by OR of mem_valid.
  - Data and address fields of an invalid channel are captured as 0.
- Duplicate squash on advance: if valid channels i<j both have wreg=1 with equal wd, wb_wreg[i] is cleared. The highest-index (youngest) write wins. wd=0 writes are still passed; regfile ignores r0.
- No internal state beyond the output registers, plus the counters when the optional feature is enabled.
- rst asserted mid-hold or mid-flush: reset wins immediately, with no clock needed.
- NUM_CH=1: squash logic degenerates to a pass-through; behaviour is identical to a single-issue stage register with a valid bit.

Optional Feature:
Macro MEM_WB_PIPE_PERF_EN.
- Defined: adds outputs perf_bubble_cnt (32) and perf_hold_cnt (32).
  - perf_bubble_cnt increments on each edge that loads a bubble (flush or stall insert).
  - perf_hold_cnt increments on each hold edge.
  - Both wrap modulo 2^32 and clear on rst.
- Undefined: ports and counters absent; all other behaviour unchanged.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - constants REG_AW_DEF=5, DW_DEF=32, STALL_W_DEF=6
  - stage index constants STG_IF..STG_WB (STG_MEM=4)
  - a typedef for the per-channel write-back record (valid, wreg, wd, wdata)
- One sub-module is natural: wb_dup_squash, the combinational NUM_CH-wide duplicate-destination squash. Reused by the future ex_mem_pipe.

Test Plan:
- Reset: drive nonzero inputs, rst=0 mid-cycle -> all outputs 0 without a clock edge; rst=1, stall=0 -> next edge captures wd0=5, wdata0=32'h1234_5678.
- Advance/hold/bubble:
  - stall=6'b000000 -> capture.
  - stall=6'b110000 -> outputs held for 3 cycles.
  - stall=6'b010000 -> next edge all outputs 0.
- Flush priority: flush=1 with stall=6'b110000 and valid inputs -> next edge all outputs 0, wb_valid=0.
- Duplicate squash: NUM_CH=2, both valid, wreg=1, wd=7, wdata0=1, wdata1=2 -> wb_wreg=2'b10, wb_wdata ch1=2.
- Invalid channel gating: mem_valid=2'b01, mem_wreg=2'b11, mem_whilo=1 -> wb_wreg=2'b01, ch1 fields 0, wb_whilo=1; then mem_valid=0 -> wb_whilo=0, wb_LLbit_we=0.
- Perf (MEM_WB_PIPE_PERF_EN defined): 3 hold edges, 2 stall-insert edges, 1 flush -> perf_hold_cnt=3, perf_bubble_cnt=3.
